// File: rtl/rpc_method_arbiter.sv
// rpc_method_arbiter
// Shares one four-phase req/ack RPC method port of a generated server between
// N_CLIENTS client threads. Arbitration is round-robin. The grantee's arguments
// are captured into a register, and the server return is broadcast back to the
// clients. A watchdog releases the grantee if the server never acks.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transaction; waiting for any cli_req
// REQ    | srv_req high for the grantee; waiting for srv_ack or watchdog expiry
// HOLD   | cli_ack high to the grantee; waiting for cli_req[g] and srv_ack low
module rpc_method_arbiter #(
    parameter int N_CLIENTS = 4,
    parameter int ARG_W     = 73,
    parameter int RET_W     = 8,
    parameter int TIMEOUT   = 1023,
    localparam int IDX_W    = $clog2(N_CLIENTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CLIENTS-1:0]         cli_req,
    input  logic [N_CLIENTS*ARG_W-1:0]   cli_args,
    output logic [N_CLIENTS-1:0]         cli_ack,
    output logic [RET_W-1:0]             cli_return,
    output logic                         srv_req,
    output logic [ARG_W-1:0]             srv_args,
    input  logic                         srv_ack,
    input  logic [RET_W-1:0]             srv_return,
    output logic [IDX_W-1:0]             grant_idx,
    output logic                         busy,
    output logic                         timeout_err
);

    // The watchdog only ever needs to count up to TIMEOUT-1.
    localparam int WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CLIENTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [WDOG_W-1:0]    wdog;
    logic                 wdog_hit;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [ARG_W-1:0]     arg_sel;
    logic [N_CLIENTS-1:0] grant_onehot;
    logic                 hold_done;
    int                   cand;

    // Round-robin pick: first requesting client at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_CLIENTS) begin
                cand = cand - N_CLIENTS;
            end
            if (!pick_found && cli_req[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Argument mux for the picked client, using constant slices only.
    always_comb begin
        arg_sel = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                arg_sel = cli_args[i*ARG_W +: ARG_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; srv_ack takes priority over watchdog expiry in REQ.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (pick_found)              state_nxt = S_REQ;
            S_REQ:  if (srv_ack || wdog_hit)     state_nxt = S_HOLD;
            S_HOLD: if (hold_done)               state_nxt = S_IDLE;
            default:                             state_nxt = S_IDLE;
        endcase
    end

    // Decodes taken from registered state only, so no input reaches an output.
    always_comb begin
        busy         = (state != S_IDLE);
        wdog_hit     = (TIMEOUT != 0) && (wdog == WDOG_LAST);
        grant_onehot = N_CLIENTS'(1) << grant_idx;
        // A late srv_ack after a timeout must fall before the next grant.
        hold_done    = !cli_req[grant_idx] && !srv_ack;
    end

    // Registered outputs and datapath: capture, return broadcast, watchdog, pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cli_ack     <= '0;
            cli_return  <= '0;
            srv_req     <= 1'b0;
            srv_args    <= '0;
            grant_idx   <= '0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            wdog        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        srv_args  <= arg_sel;
                        grant_idx <= pick_idx;
                        srv_req   <= 1'b1;
                        wdog      <= '0;
                    end
                end
                S_REQ: begin
                    if (srv_ack) begin
                        cli_return <= srv_return;
                        cli_ack    <= grant_onehot;
                        srv_req    <= 1'b0;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (wdog_hit) begin
                            timeout_err <= 1'b1;
                            srv_req     <= 1'b0;
                            cli_return  <= '0;
                            cli_ack     <= grant_onehot;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_done) begin
                        cli_ack <= '0;
                        rr_ptr  <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
                    end
                end
                default: begin
                    cli_ack <= '0;
                    srv_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
